// File: rtl/swerv_trace_fifo_if.sv
// Bundle for the retire-trace FIFO: commit-side capture group, trace-port drain side and status.
// The slave modport is the FIFO; the master modport is whoever drives the commit lanes and consumes the trace.
interface swerv_trace_fifo_if #(
    parameter int NUM_LANES  = 3,
    parameter int DEPTH      = 8,
    parameter int DROP_CNT_W = 8
);
    logic                          flush;
    logic [NUM_LANES-1:0]          in_valid;
    logic [32*NUM_LANES-1:0]       in_insn;
    logic [32*NUM_LANES-1:0]       in_addr;
    logic [NUM_LANES-1:0]          in_exception;
    logic [NUM_LANES-1:0]          in_interrupt;
    logic [4:0]                    in_ecause;
    logic [31:0]                   in_tval;

    logic                          out_valid;
    logic                          out_ready;
    logic [31:0]                   out_insn;
    logic [31:0]                   out_addr;
    logic                          out_exception;
    logic                          out_interrupt;
    logic [4:0]                    out_ecause;
    logic [31:0]                   out_tval;
    logic [1:0]                    out_lane;

    logic [$clog2(DEPTH):0]        count;
    logic                          overflow;
    logic                          clr_ovf;
    logic [DROP_CNT_W-1:0]         drop_cnt;

    modport slave (
        input  flush, in_valid, in_insn, in_addr, in_exception, in_interrupt,
               in_ecause, in_tval, out_ready, clr_ovf,
        output out_valid, out_insn, out_addr, out_exception, out_interrupt,
               out_ecause, out_tval, out_lane, count, overflow, drop_cnt
    );

    modport master (
        output flush, in_valid, in_insn, in_addr, in_exception, in_interrupt,
               in_ecause, in_tval, out_ready, clr_ovf,
        input  out_valid, out_insn, out_addr, out_exception, out_interrupt,
               out_ecause, out_tval, out_lane, count, overflow, drop_cnt
    );
endinterface

// File: rtl/swerv_trace_fifo.sv
// Retire-trace buffer: compacts up to NUM_LANES retired records per cycle into a DEPTH-entry FIFO
// and drains one record per cycle to a backpressured trace port, counting whole groups it had to drop.
module swerv_trace_fifo #(
    parameter int NUM_LANES  = 3,
    parameter int DEPTH      = 8,
    parameter int DROP_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    swerv_trace_fifo_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
        logic [1:0]  lane;
    } rec_t;

    rec_t                  r_mem [DEPTH];
    logic [AW-1:0]         r_wrPtr;
    logic [AW-1:0]         r_rdPtr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_dropCnt;

    rec_t                  w_rec  [NUM_LANES];
    logic [AW-1:0]         w_slot [NUM_LANES];
    logic [CW-1:0]         w_groupSize;
    logic [CW-1:0]         w_free;
    logic                  w_fits;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic [CW-1:0]         w_countNext;
    rec_t                  w_head;

    // Slot of each valid lane is wr_ptr plus the number of valid lanes below it, so the group lands gap-free.
    always_comb begin
        w_groupSize = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_slot[i]   = r_wrPtr + AW'(w_groupSize);
            w_groupSize = w_groupSize + CW'(bus.in_valid[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_rec[i]        = '0;
            w_rec[i].insn   = bus.in_insn[32*i +: 32];
            w_rec[i].addr   = bus.in_addr[32*i +: 32];
            w_rec[i].exc    = bus.in_exception[i];
            w_rec[i].intr   = bus.in_interrupt[i];
            w_rec[i].lane   = 2'(i);
            if (bus.in_exception[i] || bus.in_interrupt[i]) begin
                w_rec[i].ecause = bus.in_ecause;
                w_rec[i].tval   = bus.in_tval;
            end
        end
    end

    // Space is judged on the occupancy before this cycle's pop, so a full FIFO rejects even while draining.
    always_comb begin
        w_free      = CW'(DEPTH) - r_count;
        w_fits      = (w_free >= w_groupSize);
        w_push      = !bus.flush && (w_groupSize != '0) && w_fits;
        w_drop      = !bus.flush && (w_groupSize != '0) && !w_fits;
        w_pop       = !bus.flush && bus.out_valid && bus.out_ready;
        w_countNext = r_count;
        if (bus.flush) begin
            w_countNext = '0;
        end else begin
            w_countNext = r_count + (w_push ? w_groupSize : '0) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else if (w_push) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (bus.in_valid[i]) begin
                    r_mem[w_slot[i]] <= w_rec[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(w_groupSize);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count <= w_countNext;
        end
    end

    // A drop in the same cycle as a clear wins, leaving exactly one counted drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (bus.clr_ovf) begin
                r_dropCnt <= DROP_CNT_W'(1);
            end else if (r_dropCnt != {DROP_CNT_W{1'b1}}) begin
                r_dropCnt <= r_dropCnt + DROP_CNT_W'(1);
            end
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end
    end

    assign w_head            = r_mem[r_rdPtr];
    assign bus.out_valid     = (r_count != '0);
    assign bus.out_insn      = w_head.insn;
    assign bus.out_addr      = w_head.addr;
    assign bus.out_exception = w_head.exc;
    assign bus.out_interrupt = w_head.intr;
    assign bus.out_ecause    = w_head.ecause;
    assign bus.out_tval      = w_head.tval;
    assign bus.out_lane      = w_head.lane;
    assign bus.count         = r_count;
    assign bus.overflow      = r_overflow;
    assign bus.drop_cnt      = r_dropCnt;

`ifndef SYNTHESIS
    countBound: assert property (@(posedge clk) disable iff (rst) int'(r_count) <= DEPTH);
    laneBound:  assert property (@(posedge clk) disable iff (rst) int'(bus.out_lane) < NUM_LANES);
`endif
endmodule
